// File: rtl/spi_arb_if.sv
// Bundle of requester-side and SPI-monarch-side signals around the arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface spi_arb_if;
    logic        req0;
    logic        req1;
    logic [15:0] cmd0;
    logic [15:0] cmd1;
    logic        ack0;
    logic        ack1;
    logic        err;
    logic [15:0] resp;
    logic        busy;
    logic        wrt;
    logic [15:0] cmd;
    logic        done;
    logic [15:0] rd_data;
    logic [1:0]  dbg_state;

    // Handshake: reqN is a level held until the one-cycle ackN; cmdN is stable
    // while reqN is high. The monarch gets a one-cycle wrt with cmd held, and
    // answers with a one-cycle done carrying rd_data.
    modport slave (
        input  req0, req1, cmd0, cmd1, done, rd_data,
        output ack0, ack1, err, resp, busy, wrt, cmd, dbg_state
    );

    modport master (
        output req0, req1, cmd0, cmd1, done, rd_data,
        input  ack0, ack1, err, resp, busy, wrt, cmd, dbg_state
    );
endinterface

// File: rtl/spi_arb.sv
// Round-robin arbiter sharing one SPI monarch between two requesters, with a
// watchdog that aborts transactions whose done never arrives.
module spi_arb #(
    parameter int TIMEOUT = 1024
) (
    input logic       clk,
    input logic       rst,
    spi_arb_if.slave  bus
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_ACK   = 2'd3
    } state_e;

    state_e        state_q;
    logic          last_q;
    logic          owner_q;
    logic [TW-1:0] timer_q;
    logic          tmo_q;
    logic [15:0]   cmd_q;
    logic [15:0]   resp_q;
    logic          wrt_q;
    logic          ack0_q;
    logic          ack1_q;
    logic          err_q;
    logic          grant1;

    // Port 1 wins when alone, or when both ask and port 0 was served last.
    always_comb begin
        grant1 = bus.req1 && (!bus.req0 || !last_q);
    end

    // tmo_q marks that the final allowed WAIT cycle has been reached; the
    // abort is taken one cycle later so a done in that last cycle still wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            timer_q <= '0;
            tmo_q   <= 1'b0;
            cmd_q   <= 16'h0000;
            resp_q  <= 16'h0000;
            wrt_q   <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            wrt_q  <= 1'b0;
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        owner_q <= grant1;
                        cmd_q   <= grant1 ? bus.cmd1 : bus.cmd0;
                        wrt_q   <= 1'b1;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    timer_q <= '0;
                    tmo_q   <= 1'b0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    timer_q <= timer_q + 1'b1;
                    if (timer_q == TMAX) begin
                        tmo_q <= 1'b1;
                    end
                    if (bus.done) begin
                        resp_q  <= bus.rd_data;
                        err_q   <= 1'b0;
                        ack0_q  <= ~owner_q;
                        ack1_q  <= owner_q;
                        state_q <= S_ACK;
                    end else if (tmo_q) begin
                        resp_q  <= 16'h0000;
                        err_q   <= 1'b1;
                        ack0_q  <= ~owner_q;
                        ack1_q  <= owner_q;
                        state_q <= S_ACK;
                    end
                end
                S_ACK: begin
                    last_q  <= owner_q;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.busy      = (state_q != S_IDLE);
    assign bus.wrt       = wrt_q;
    assign bus.cmd       = cmd_q;
    assign bus.ack0      = ack0_q;
    assign bus.ack1      = ack1_q;
    assign bus.err       = err_q;
    assign bus.resp      = resp_q;
    assign bus.dbg_state = state_q;
endmodule
